// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states
// and the single-cycle op classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ZERO = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_MUL  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } alu_state_e;

    function automatic logic is_single_cycle(input alu_op_e op);
        return !(op inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL});
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational part of the ALU: ops 0-7, everything else yields 0.
// Ports: op (alu_op_e), x/y operands, res result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:  res = x + y;
            ALU_SUB:  res = x - y;
            // True signed compare, immune to x-y overflow
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, x < y};
            ALU_AND:  res = x & y;
            ALU_OR:   res = x | y;
            ALU_XOR:  res = x ^ y;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Shifts iterate
// one bit per cycle, MUL is a WIDTH-cycle radix-2 shift-add.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, op, x, y
// request side; out_valid/out_ready, out, zero result side.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_valid;

    logic [WIDTH-1:0] w_comb;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sh_x;
    logic [WIDTH-1:0] w_sh_r;
    logic [WIDTH-1:0] w_acc_nx;

    function automatic logic [WIDTH-1:0] sh1(
        input alu_op_e          o,
        input logic [WIDTH-1:0] v
    );
        case (o)
            ALU_SLL: return {v[WIDTH-2:0], 1'b0};
            ALU_SRA: return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op  (op),
        .x   (x),
        .y   (y),
        .res (w_comb)
    );

    assign w_shamt  = y[SHW-1:0];
    // First shift / multiply step is done in the accept cycle so that
    // the total latency is shamt (resp. WIDTH) cycles.
    assign w_sh_x   = sh1(op, x);
    assign w_sh_r   = sh1(r_op, r_a);
    assign w_acc_nx = r_acc + (r_b[0] ? r_a : '0);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_valid;
    assign out       = r_out;
    assign zero      = r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= ALU_ZERO;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op <= op;
                    if (is_single_cycle(op)) begin
                        r_out   <= w_comb;
                        r_zero  <= (w_comb == '0);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (op == ALU_MUL) begin
                        r_acc   <= y[0] ? x : '0;
                        r_a     <= x << 1;
                        r_b     <= y >> 1;
                        r_cnt   <= SHW'(WIDTH - 1);
                        r_state <= MUL;
                    end else if (w_shamt == '0) begin
                        r_out   <= x;
                        r_zero  <= (x == '0);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_shamt == SHW'(1)) begin
                        r_out   <= w_sh_x;
                        r_zero  <= (w_sh_x == '0);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_a     <= w_sh_x;
                        r_cnt   <= w_shamt - SHW'(1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= w_sh_r;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_out   <= w_sh_r;
                        r_zero  <= (w_sh_r == '0);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                MUL: begin
                    r_acc <= w_acc_nx;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_out   <= w_acc_nx;
                        r_zero  <= (w_acc_nx == '0);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_zero  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and back-to-back checks of alu_mc, WIDTH=32 and WIDTH=8.
// Drives on negedge, samples on negedge.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv[2];
    logic        ordy[2];
    alu_op_e     opv[2];
    logic [31:0] xv[2];
    logic [31:0] yv[2];
    logic        ir[2];
    logic        ov[2];
    logic        z[2];
    logic [31:0] os[2];
    logic [31:0] o32;
    logic [7:0]  o8;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .op(opv[0]), .x(xv[0]), .y(yv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(o32), .zero(z[0])
    );

    alu_mc #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .op(opv[1]), .x(xv[1][7:0]), .y(yv[1][7:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(o8), .zero(z[1])
    );

    assign os[0] = o32;
    assign os[1] = {24'd0, o8};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int w,
        input logic [3:0] o, input logic [31:0] a_i, input logic [31:0] b_i);
        logic [31:0] m, sb, a, b, r;
        int sh;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a  = a_i & m;
        b  = b_i & m;
        sb = 32'd1 << (w - 1);
        sh = int'(b & 32'(w - 1));
        case (o)
            4'd1:    r = a + b;
            4'd2:    r = a - b;
            4'd3:    r = ((a ^ sb) < (b ^ sb)) ? 32'd1 : 32'd0;
            4'd4:    r = (a < b) ? 32'd1 : 32'd0;
            4'd5:    r = a & b;
            4'd6:    r = a | b;
            4'd7:    r = a ^ b;
            4'd8:    r = a << sh;
            4'd9:    r = a >> sh;
            4'd10:   r = (a >> sh) | (((a & sb) != 0) ? (m & ~(m >> sh)) : 32'd0);
            4'd11:   r = a * b;
            default: r = 32'd0;
        endcase
        return r & m;
    endfunction

    task automatic do_op(input string tag, input alu_op_e o,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        opv[0] = o; xv[0] = a; yv[0] = b;
        iv[0] = 1'b1; ordy[0] = 1'b1;
        n = 0;
        while (!ir[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir[0]) begin
            chk({tag, "_acc"}, 32'd0, 32'd1);
            iv[0] = 1'b0;
            return;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        n = 1;
        while (!ov[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_val"}, 32'(ov[0]), 32'd1);
        chk({tag, "_out"}, os[0], exp);
        chk({tag, "_z"}, 32'(z[0]), 32'(exp == 32'd0));
        chk({tag, "_lat"}, 32'(n), 32'(lat));
    endtask

    task automatic new_req(input int k);
        opv[k] = alu_op_e'(4'($urandom_range(0, 15)));
        xv[k]  = $urandom;
        yv[k]  = $urandom;
    endtask

    task automatic b2b(input int k, input int w, input string tag);
        logic [31:0] q[$];
        int sent, got, cyc;
        bit flag;
        sent = 0; got = 0; cyc = 0; flag = 0;
        @(negedge clk);
        ordy[k] = 1'b1;
        new_req(k);
        iv[k] = 1'b1;
        while ((sent < 20 || q.size() > 0) && cyc < 2000) begin
            if (ov[k]) begin
                if (q.size() == 0) chk({tag, "_dup"}, 32'd1, 32'd0);
                else chk({tag, "_res"}, os[k], q.pop_front());
                got++;
            end
            if (flag) begin
                flag = 0;
                if (sent < 20) new_req(k);
                else iv[k] = 1'b0;
            end
            if (iv[k] && ir[k]) begin
                q.push_back(ref_alu(w, opv[k], xv[k], yv[k]));
                sent++;
                flag = 1;
            end
            @(negedge clk);
            cyc++;
        end
        iv[k] = 1'b0;
        chk({tag, "_cnt"}, 32'(got), 32'd20);
    endtask

    initial begin
        bit seen;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1;
            opv[k] = ALU_ZERO; xv[k] = '0; yv[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_out", os[0], 32'd0);
        chk("rst_vld", 32'(ov[0]), 32'd0);
        chk("rst_rdy", 32'(ir[0]), 32'd1);
        chk("rst_z", 32'(z[0]), 32'd0);
        rst_n = 1'b1;

        do_op("add", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        do_op("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        do_op("slt", ALU_SLT, 32'h8000_0000, 32'd1, 32'd1, 1);
        do_op("sltu", ALU_SLTU, 32'h8000_0000, 32'd1, 32'd0, 1);
        do_op("xor", ALU_XOR, 32'hF0F0, 32'h0FF0, 32'hFF00, 1);
        do_op("and", ALU_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 1);
        do_op("or", ALU_OR, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1);
        do_op("op13", alu_op_e'(4'd13), 32'h1234, 32'h5678, 32'd0, 1);
        do_op("sra31", ALU_SRA, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF, 31);
        do_op("sra4", ALU_SRA, 32'h4000_0000, 32'h4, 32'h0400_0000, 4);
        do_op("sll4", ALU_SLL, 32'd1, 32'h24, 32'h10, 4);
        do_op("srl0", ALU_SRL, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1);
        do_op("srl1", ALU_SRL, 32'h8000_0000, 32'd1, 32'h4000_0000, 1);
        do_op("mul", ALU_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32);
        do_op("mulff", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32);

        // backpressure
        @(negedge clk);
        opv[0] = ALU_SUB; xv[0] = 32'd5; yv[0] = 32'd5;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        @(negedge clk);
        opv[0] = ALU_ADD; xv[0] = 32'd1; yv[0] = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(ov[0]), 32'd1);
            chk("bp_out", os[0], 32'd0);
            chk("bp_z", 32'(z[0]), 32'd1);
            chk("bp_rdy", 32'(ir[0]), 32'd0);
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_rel_vld", 32'(ov[0]), 32'd0);
        chk("bp_rel_rdy", 32'(ir[0]), 32'd1);
        @(negedge clk);
        iv[0] = 1'b0;
        chk("bp_next_vld", 32'(ov[0]), 32'd1);
        chk("bp_next_out", os[0], 32'd3);
        @(negedge clk);

        // reset during MUL
        @(negedge clk);
        opv[0] = ALU_MUL; xv[0] = 32'd3; yv[0] = 32'd5; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("mrst_busy", 32'(ir[0]), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(ov[0]), 32'd0);
        chk("mrst_rdy", 32'(ir[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        chk("mrst_ghost", 32'(seen), 32'd0);
        do_op("mul_after", ALU_MUL, 32'd3, 32'd5, 32'd15, 32);

        b2b(0, 32, "b2b32");
        b2b(1, 8, "b2b8");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
